mips_multicycle: RTL and testbench
==================================

# mips_multicycle

Multicycle 32-bit MIPS processor core for the teaching SoC: one shared-clock FSM fetches, decodes, executes and writes back a subset of the MIPS-I integer ISA, one instruction at a time. Instruction and data memories are internal word arrays. The core is the top of the CPU hierarchy. It has no external bus, and the bench observes it through debug outputs and fixed internal instance names.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low: sampled on the rising edge of clk, asserted when 0.
- pc_o  output  32  current PC, mirrors the internal PC register.
- ir_o  output  32  current instruction register.
- Fixed hierarchy for bench access:
  - instance U_PC holds the 32-bit register PC.
  - instance U_IM holds reg [31:0] imem[0:1023], loadable by $readmemh.
  - top-level wire instr equals ir_o.

## Operation
- ISA subset:
  - addu, subu, and, or, slt, jr (R-type).
  - addiu, ori, lui, lw, sw, beq, j, jal.
- Unsupported opcode or funct: executes as NOP and returns to FETCH after DECODE.
- Register file: 32×32. $0 always reads 0 and writes to it are discarded. Two async read ports, one sync write port.
- Immediates:
  - addiu, lw, sw: sign-extended.
  - ori: zero-extended.
  - lui: imm<<16.
- slt is a signed compare. addu/subu/addiu wrap modulo 2^32 with no overflow trap.
- Addressing:
  - Instruction memory is indexed by PC[11:2].
  - Data memory (1024 words, zero at power-up, not cleared by reset) is indexed by ALU result [11:2].
  - Address bits [1:0] are ignored; word access only.
- FSM states:
  - FETCH: IR←imem[PC[11:2]], PC←PC+4.
  - DECODE: latch A←rs, B←rt.
    - j/jal/jr complete here: PC←{PC[31:28],target,00} or A.
    - jal also writes $31←PC (already PC+4).
  - EXEC: compute ALU result.
    - beq completes here: if A==B, PC←PC+(sext(imm)<<2).
  - MEM: lw reads the data word; sw writes B and completes.
  - WB: write rd (R-type) or rt (I-type/lw).
- Transitions:
  - FETCH→DECODE always.
  - DECODE→FETCH for j/jal/jr/unsupported; otherwise →EXEC.
  - EXEC→FETCH for beq; →MEM for lw/sw; →WB for ALU ops.
  - MEM→WB for lw; →FETCH for sw.
  - WB→FETCH.

## Timing
- Reset (rst=0 at a rising edge):
  - PC←0x00003000, IR←0, state←FETCH.
  - All registers ←0; pc_o=0x00003000, ir_o=0.
- Reset asserted mid-instruction aborts it. Writes not yet committed are lost; earlier committed register/memory writes persist.
- First fetch occurs on the first rising edge with rst=1.
- Cycles per instruction:
  - j/jal/jr/unsupported: 2.
  - beq: 3.
  - sw and ALU ops: 4.
  - lw: 5.
- Register write in WB is visible to the next instruction's DECODE.
- No interrupts or exceptions. The PC is unchanged by overflow.

## Configuration
- MIPS_TRACE_EN:
  - Defined: every FETCH edge $display's "PC = 0x%08X, IR = 0x%08X" for the instruction fetched, and every register-file write prints "$%d <= 0x%08X".
  - Undefined: no simulation output; logic is identical.

## Test plan
- Reset: hold rst=0 for 2 edges, then release → pc_o=0x00003000 and ir_o=0 during reset. First fetch loads imem[0]; PC becomes 0x00003004.
- ALU sequence: ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2 → $3=0xABCD1234. slt $4,$2,$1 → $4=1 (signed negative < positive).
- Memory: sw $3,8($0) then lw $5,8($0) → $5=0xABCD1234. The sw takes 4 cycles and the lw 5.
- Branch: beq $0,$0,-1 → PC returns to the beq's own address every 3 cycles. A not-taken beq advances PC by 4.
- Jumps: jal at 0x00003010 → $31=0x00003014 and PC=target. A following jr $31 returns to 0x00003014 in 2 cycles.
- $0 protection and mid-op reset: addiu $0,$0,5 → $0 reads 0. Asserting rst during the EXEC of a lw leaves the destination register unchanged and PC=0x00003000.

Source files
------------

// File: rtl/mips_multicycle.sv
// mips_multicycle -- multicycle 32-bit MIPS-I subset core (teaching SoC).
//
// One instruction at a time through FETCH / DECODE / EXEC / MEM / WB.
// Instruction and data memories are internal word arrays.
//
// Ports:
//   clk   in   1  system clock, all state updates on the rising edge
//   rst   in   1  synchronous active-low reset (asserted when 0)
//   pc_o  out 32  current PC (mirrors U_PC.PC)
//   ir_o  out 32  current instruction register
//
// Fixed hierarchy: U_PC.PC (program counter), U_IM.imem[0:1023]
// (instruction words, preloadable by the bench), top-level wire instr == ir_o.
//
// Build option: define MIPS_TRACE_EN to print every fetch and every
// register-file write; logic is identical either way.

// Program counter register; boots to 0x00003000.
module mips_pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  logic [31:0] PC;

  // PC update, synchronous active-low reset to the boot vector
  always_ff @(posedge clk) begin
    if (!rst) begin
      PC <= 32'h0000_3000;
    end else if (we_i) begin
      PC <= d_i;
    end
  end

  assign q_o = PC;
endmodule

// Instruction memory: 1024 words, asynchronous read. The write port is
// tied off inside the core; contents are normally preloaded by the bench.
module mips_imem (
  input  logic        clk,
  input  logic        we_i,
  input  logic [9:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [9:0]  raddr_i,
  output logic [31:0] rdata_o
);
  reg [31:0] imem [0:1023];

  // Optional load port
  always_ff @(posedge clk) begin
    if (we_i) begin
      imem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = imem[raddr_i];
endmodule

module mips_multicycle (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ   = 6'h04, OP_ADDIU = 6'h09, OP_ORI = 6'h0D,
                         OP_LUI   = 6'h0F, OP_LW = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_JR  = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR   = 6'h25, FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  state_e state_q, state_d;

  logic [31:0] pc_s, pc_d, imem_rdata;
  logic [31:0] ir_q, a_q, b_q, alu_q, mdr_q, alu_s;
  logic [31:0] rf_q   [0:31];
  logic [31:0] dmem_q [0:1023];
  logic        pc_we, ir_we, ab_we, alu_we, mdr_we, dmem_we, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  wire  [31:0] instr;

  mips_pc_reg U_PC (.clk(clk), .rst(rst), .we_i(pc_we), .d_i(pc_d), .q_o(pc_s));

  mips_imem U_IM (.clk(clk), .we_i(1'b0), .waddr_i(10'd0), .wdata_i(32'd0),
                  .raddr_i(pc_s[11:2]), .rdata_o(imem_rdata));

  assign instr = ir_q;
  assign ir_o  = instr;
  assign pc_o  = pc_s;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] sext_imm, rs_val, rt_val;
  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign target   = ir_q[25:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  // $0 is hard-wired: its storage is never written, so force the read
  assign rs_val   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  // Instruction class decode; anything unmatched falls through as a NOP
  logic is_alu_r, is_alu_i, is_jr, is_jump, is_jal, is_beq, is_lw, is_sw;
  always_comb begin
    is_alu_r = 1'b0; is_alu_i = 1'b0; is_jr = 1'b0; is_jump = 1'b0;
    is_jal   = 1'b0; is_beq   = 1'b0; is_lw = 1'b0; is_sw   = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: is_alu_r = 1'b1;
          FN_JR:   is_jr    = 1'b1;
          default: is_alu_r = 1'b0;
        endcase
      end
      OP_J:                     is_jump  = 1'b1;
      OP_JAL:   begin           is_jump  = 1'b1; is_jal = 1'b1; end
      OP_BEQ:                   is_beq   = 1'b1;
      OP_ADDIU, OP_ORI, OP_LUI: is_alu_i = 1'b1;
      OP_LW:                    is_lw    = 1'b1;
      OP_SW:                    is_sw    = 1'b1;
      default:                  is_alu_r = 1'b0;
    endcase
  end

  // ALU on the latched operands; lw/sw share the addiu address adder
  always_comb begin
    alu_s = 32'd0;
    if (is_alu_r) begin
      case (funct)
        FN_ADDU: alu_s = a_q + b_q;
        FN_SUBU: alu_s = a_q - b_q;
        FN_AND:  alu_s = a_q & b_q;
        FN_OR:   alu_s = a_q | b_q;
        FN_SLT:  alu_s = {31'd0, ($signed(a_q) < $signed(b_q))};
        default: alu_s = 32'd0;
      endcase
    end else begin
      case (op)
        OP_ADDIU, OP_LW, OP_SW: alu_s = a_q + sext_imm;
        OP_ORI:  alu_s = a_q | {16'd0, imm};
        OP_LUI:  alu_s = {imm, 16'd0};
        default: alu_s = 32'd0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (is_alu_r || is_alu_i || is_beq || is_lw || is_sw) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (is_beq)             state_d = S_FETCH;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                    state_d = S_WB;
      end
      S_MEM:    state_d = is_lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // FSM outputs: datapath enables and PC / register-file write sources
  always_comb begin
    pc_we = 1'b0; pc_d = pc_s; ir_we = 1'b0; ab_we = 1'b0; alu_we = 1'b0;
    mdr_we = 1'b0; dmem_we = 1'b0; rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
    case (state_q)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        pc_d  = pc_s + 32'd4;
      end
      S_DECODE: begin
        ab_we = 1'b1;
        if (is_jump) begin
          pc_we = 1'b1;
          pc_d  = {pc_s[31:28], target, 2'b00};
        end else if (is_jr) begin
          // A is being latched this same edge, so take rs straight from the file
          pc_we = 1'b1;
          pc_d  = rs_val;
        end else begin
          pc_we = 1'b0;
        end
        if (is_jal) begin
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = pc_s;          // already PC+4 of the jal
        end else begin
          rf_we = 1'b0;
        end
      end
      S_EXEC: begin
        alu_we = 1'b1;
        if (is_beq && (a_q == b_q)) begin
          pc_we = 1'b1;
          pc_d  = pc_s + {sext_imm[29:0], 2'b00};
        end else begin
          pc_we = 1'b0;
        end
      end
      S_MEM: begin
        if (is_lw)      mdr_we  = 1'b1;
        else if (is_sw) dmem_we = 1'b1;
        else            mdr_we  = 1'b0;
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = is_alu_r ? rd : rt;
        rf_wdata = is_lw ? mdr_q : alu_q;
      end
      default: pc_we = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_q <= 32'd0; a_q <= 32'd0; b_q <= 32'd0; alu_q <= 32'd0; mdr_q <= 32'd0;
    end else begin
      if (ir_we)  ir_q  <= imem_rdata;
      if (ab_we)  begin a_q <= rs_val; b_q <= rt_val; end
      if (alu_we) alu_q <= alu_s;
      if (mdr_we) mdr_q <= dmem_q[alu_q[11:2]];
    end
  end

  // Register-file write port; contents survive reset, a reset edge drops the write
  always_ff @(posedge clk) begin
    if (rst && rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge clk) begin
    if (rst && dmem_we) begin
      dmem_q[alu_q[11:2]] <= b_q;
    end
  end

`ifdef MIPS_TRACE_EN
  // Simulation trace of fetched instructions and committed register writes
  always @(posedge clk) begin
    if (rst && (state_q == S_FETCH)) begin
      $display("PC = 0x%08X, IR = 0x%08X", pc_s, imem_rdata);
    end
    if (rst && rf_we && (rf_waddr != 5'd0)) begin
      $display("$%d <= 0x%08X", rf_waddr, rf_wdata);
    end
  end
`else
  // Normal builds produce no trace output.
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle. An instruction-level reference
// model (architectural PC/IR, registers, data memory, per-class cycle counts)
// predicts pc_o/ir_o after every clock edge; register contents are checked
// at phase boundaries and pinned with hand-computed literals.
module tb_mips_multicycle;
  logic        clk;
  logic        rst;
  logic [31:0] pc_o, ir_o;

  mips_multicycle dut (.clk(clk), .rst(rst), .pc_o(pc_o), .ir_o(ir_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  logic [31:0] m_imem [0:1023];
  logic [31:0] m_dmem [0:1023];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc, m_ir, m_nxt_pc, m_wr_val, m_mem_val;
  logic [4:0]  m_wr_idx;
  logic [9:0]  m_mem_idx;
  logic        m_wr_reg, m_wr_mem;
  int          m_k, m_len, m_pc_cyc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 25)
        $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Work out what the just-fetched instruction will do and when
  task automatic model_plan();
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, simm, ea;
    op = m_ir[31:26]; fn = m_ir[5:0];
    rs = m_ir[25:21]; rt = m_ir[20:16]; rd = m_ir[15:11];
    a = m_regs[rs]; b = m_regs[rt];
    simm = {{16{m_ir[15]}}, m_ir[15:0]};
    ea = a + simm;
    m_len = 2; m_pc_cyc = -1; m_nxt_pc = 32'd0;
    m_wr_reg = 1'b0; m_wr_idx = 5'd0; m_wr_val = 32'd0;
    m_wr_mem = 1'b0; m_mem_idx = ea[11:2]; m_mem_val = b;
    case (op)
      6'h00: begin
        m_len = 4; m_wr_reg = 1'b1; m_wr_idx = rd;
        case (fn)
          6'h21: m_wr_val = a + b;
          6'h23: m_wr_val = a - b;
          6'h24: m_wr_val = a & b;
          6'h25: m_wr_val = a | b;
          6'h2A: m_wr_val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h08: begin m_len = 2; m_wr_reg = 1'b0; m_pc_cyc = 1; m_nxt_pc = a; end
          default: begin m_len = 2; m_wr_reg = 1'b0; end
        endcase
      end
      6'h09: begin m_len = 4; m_wr_reg = 1'b1; m_wr_idx = rt; m_wr_val = ea; end
      6'h0D: begin m_len = 4; m_wr_reg = 1'b1; m_wr_idx = rt; m_wr_val = a | {16'd0, m_ir[15:0]}; end
      6'h0F: begin m_len = 4; m_wr_reg = 1'b1; m_wr_idx = rt; m_wr_val = {m_ir[15:0], 16'd0}; end
      6'h23: begin m_len = 5; m_wr_reg = 1'b1; m_wr_idx = rt; m_wr_val = m_dmem[ea[11:2]]; end
      6'h2B: begin m_len = 4; m_wr_mem = 1'b1; end
      6'h04: begin
        m_len = 3;
        if (a == b) begin m_pc_cyc = 2; m_nxt_pc = m_pc + (simm << 2); end
      end
      6'h02: begin m_pc_cyc = 1; m_nxt_pc = {m_pc[31:28], m_ir[25:0], 2'b00}; end
      6'h03: begin
        m_pc_cyc = 1; m_nxt_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
        m_wr_reg = 1'b1; m_wr_idx = 5'd31; m_wr_val = m_pc;
      end
      default: m_len = 2;
    endcase
  endtask

  // Advance the model by one clock edge
  task automatic model_edge();
    if (!rst) begin
      m_pc = 32'h0000_3000; m_ir = 32'd0; m_k = 0;
    end else if (m_k == 0) begin
      m_ir = m_imem[m_pc[11:2]];
      m_pc = m_pc + 32'd4;
      model_plan();
      m_k = 1;
    end else begin
      if (m_k == m_pc_cyc) m_pc = m_nxt_pc;
      if (m_k == m_len - 1) begin
        if (m_wr_reg && (m_wr_idx != 5'd0)) m_regs[m_wr_idx] = m_wr_val;
        if (m_wr_mem) m_dmem[m_mem_idx] = m_mem_val;
        m_k = 0;
      end else begin
        m_k = m_k + 1;
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check32("pc_o", pc_o, m_pc);
    check32("ir_o", ir_o, m_ir);
    check32("instr", dut.instr, m_ir);
  endtask

  task automatic load_word(input int idx, input logic [31:0] w);
    dut.U_IM.imem[idx[9:0]] = w;
    m_imem[idx[9:0]] = w;
  endtask

  task automatic check_regs(input string tag);
    for (int r = 1; r < 32; r++) check32(tag, dut.rf_q[r], m_regs[r]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int k, off;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    k   = int'($urandom_range(0, 15));
    case (k)
      0:  return enc_r(rs, rt, rd, 6'h21);
      1:  return enc_r(rs, rt, rd, 6'h23);
      2:  return enc_r(rs, rt, rd, 6'h24);
      3:  return enc_r(rs, rt, rd, 6'h25);
      4:  return enc_r(rs, rt, rd, 6'h2A);
      5:  return enc_r(rs, 5'd0, 5'd0, 6'h08);
      6:  return enc_i(6'h09, rs, rt, imm);
      7:  return enc_i(6'h0D, rs, rt, imm);
      8:  return enc_i(6'h0F, 5'd0, rt, imm);
      9:  return enc_i(6'h23, rs, rt, 16'($urandom_range(0, 63)));
      10: return enc_i(6'h2B, rs, rt, 16'($urandom_range(0, 63)));
      11: begin off = int'($urandom_range(0, 9)) - 3; return enc_i(6'h04, rs, rt, 16'(off)); end
      12: return enc_j(6'h02, 26'($urandom_range(0, 1023)));
      13: return enc_j(6'h03, 26'($urandom_range(0, 1023)));
      14: return {6'h3F, 26'($urandom)};
      default: return {6'h00, rs, rt, rd, 5'd3, 6'h00};
    endcase
  endfunction

  logic [31:0] prog [0:16];
  int t_sw, t_lw, t_j;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 1024; i++) begin m_dmem[i] = 32'd0; load_word(i, 32'd0); end

    prog[0]  = enc_i(6'h0D, 5'd0, 5'd1, 16'h1234);      // ori  $1,$0,0x1234
    prog[1]  = enc_i(6'h0F, 5'd0, 5'd2, 16'hABCD);      // lui  $2,0xABCD
    prog[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h21);          // addu $3,$1,$2
    prog[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);          // slt  $4,$2,$1
    prog[4]  = enc_j(6'h03, 26'h0000C08);               // jal  0x3020
    prog[5]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0008);      // sw   $3,8($0)
    prog[6]  = enc_i(6'h23, 5'd0, 5'd5, 16'h0008);      // lw   $5,8($0)
    prog[7]  = enc_j(6'h02, 26'h0000C0A);               // j    0x3028
    prog[8]  = enc_i(6'h09, 5'd0, 5'd0, 16'h0005);      // addiu $0,$0,5
    prog[9]  = enc_r(5'd31, 5'd0, 5'd0, 6'h08);         // jr   $31
    prog[10] = enc_i(6'h04, 5'd1, 5'd2, 16'h0005);      // beq  $1,$2,+5 (not taken)
    prog[11] = enc_r(5'd1, 5'd2, 5'd6, 6'h23);          // subu $6,$1,$2
    prog[12] = enc_r(5'd3, 5'd1, 5'd7, 6'h24);          // and  $7,$3,$1
    prog[13] = enc_r(5'd1, 5'd2, 5'd8, 6'h25);          // or   $8,$1,$2
    prog[14] = enc_r(5'd0, 5'd1, 5'd9, 6'h21);          // addu $9,$0,$1
    prog[15] = 32'hFC00_0000;                           // unsupported opcode
    prog[16] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);      // beq  $0,$0,-1
    for (int i = 0; i < 17; i++) load_word(i, prog[i]);

    // Reset held for two edges
    tick(); tick();
    check32("reset_pc", pc_o, 32'h0000_3000);
    check32("reset_ir", ir_o, 32'd0);
    rst = 1'b1;
    tick();
    check32("first_fetch_pc", pc_o, 32'h0000_3004);
    check32("first_fetch_ir", ir_o, 32'h3401_1234);

    t_sw = -1; t_lw = -1; t_j = -1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (t_sw < 0 && ir_o == prog[5]) t_sw = cyc;
      if (t_lw < 0 && ir_o == prog[6]) t_lw = cyc;
      if (t_j  < 0 && ir_o == prog[7]) t_j  = cyc;
    end
    check32("sw_cycles", 32'(t_lw - t_sw), 32'd4);
    check32("lw_cycles", 32'(t_j - t_lw), 32'd5);
    check32("r1",  dut.rf_q[1],  32'h0000_1234);
    check32("r2",  dut.rf_q[2],  32'hABCD_0000);
    check32("r3",  dut.rf_q[3],  32'hABCD_1234);
    check32("r4_slt", dut.rf_q[4], 32'd1);
    check32("r5_lw", dut.rf_q[5], 32'hABCD_1234);
    check32("r6_subu", dut.rf_q[6], 32'h5433_1234);
    check32("r7_and", dut.rf_q[7], 32'h0000_1234);
    check32("r8_or", dut.rf_q[8], 32'hABCD_1234);
    check32("r9_zero_src", dut.rf_q[9], 32'h0000_1234);
    check32("r31_jal", dut.rf_q[31], 32'h0000_3014);
    check32("model_r5", m_regs[5], 32'hABCD_1234);
    check32("model_r31", m_regs[31], 32'h0000_3014);
    check_regs("regs_directed");

    // Reset while a lw sits in EXEC: its write to $1 must be lost
    rst = 1'b0;
    load_word(0, enc_i(6'h23, 5'd0, 5'd1, 16'h0008)); // lw $1,8($0)
    tick(); tick();
    rst = 1'b1;
    tick(); tick();                                     // FETCH, DECODE
    rst = 1'b0;
    tick();
    check32("midreset_r1", dut.rf_q[1], 32'h0000_1234);
    check32("midreset_pc", pc_o, 32'h0000_3000);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    check_regs("regs_midreset");

    // Randomised programs over the whole instruction memory
    for (int p = 0; p < 3; p++) begin
      rst = 1'b0;
      for (int i = 0; i < 1024; i++) load_word(i, rand_instr());
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 2500; i++) tick();
      check_regs("regs_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
